glb_block_framer: RTL

GLB_BLOCK_FRAMER -- requirements
Module: glb_block_framer

---
 rtl/glb_block_framer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/glb_block_framer.sv
// Frames a GLB word stream into length-prefixed blocks followed by a done token.
// A 2-entry FIFO decouples the GLB side from the block-stream consumer.
module glb_block_framer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        tile_en,
    input  logic [15:0] cfg_tx_num,
    input  logic [15:0] glb_data,
    input  logic        glb_valid,
    output logic        glb_ready,
    output logic [16:0] blk_out,
    output logic        blk_out_valid,
    input  logic        blk_out_ready,
    output logic        done,
    output logic [15:0] blk_count
);
    localparam logic [16:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE_TOK, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] remaining, remaining_nxt;
    logic [15:0] tx_num, tx_num_nxt;
    logic [15:0] blk_count_nxt;
    logic [15:0] count_inc;

    logic [16:0] fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_cnt;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic [16:0] push_word;
    logic        glb_xfer, blk_done;

    assign fifo_full     = (fifo_cnt == 2'd2);
    assign fifo_empty    = (fifo_cnt == 2'd0);
    // Readiness uses the registered occupancy only, so a same-cycle pop never frees a slot.
    assign glb_ready     = clk_en && ((state == HEADER) || (state == DATA)) && !fifo_full;
    assign blk_out_valid = clk_en && !fifo_empty;
    assign blk_out       = fifo_empty ? 17'd0 : fifo_mem[rd_ptr];
    assign done          = (state == DONE);
    assign glb_xfer      = glb_valid && glb_ready;
    assign pop           = blk_out_valid && blk_out_ready;
    assign count_inc     = (blk_count == 16'hFFFF) ? blk_count : blk_count + 16'd1;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        tx_num_nxt    = tx_num;
        blk_count_nxt = blk_count;
        push          = 1'b0;
        push_word     = {1'b0, glb_data};
        blk_done      = 1'b0;
        case (state)
            IDLE: begin
                if (tile_en) begin
                    tx_num_nxt = cfg_tx_num;
                    state_nxt  = (cfg_tx_num != 16'd0) ? HEADER : DONE_TOK;
                end
            end
            HEADER: begin
                if (glb_xfer) begin
                    push          = 1'b1;
                    remaining_nxt = glb_data;
                    if (glb_data != 16'd0) state_nxt = DATA;
                    else                   blk_done  = 1'b1;
                end
            end
            DATA: begin
                if (glb_xfer) begin
                    push          = 1'b1;
                    remaining_nxt = remaining - 16'd1;
                    if (remaining == 16'd1) blk_done = 1'b1;
                end
            end
            DONE_TOK: begin
                if (clk_en && !fifo_full) begin
                    push      = 1'b1;
                    push_word = DONE_TOKEN;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // Block completion decides between another header and the done token.
        if (blk_done) begin
            blk_count_nxt = count_inc;
            state_nxt     = (count_inc == tx_num) ? DONE_TOK : HEADER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 16'd0;
            tx_num    <= 16'd0;
            blk_count <= 16'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else if (flush) begin
            state     <= IDLE;
            remaining <= 16'd0;
            tx_num    <= 16'd0;
            blk_count <= 16'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else if (clk_en) begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            tx_num    <= tx_num_nxt;
            blk_count <= blk_count_nxt;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt  <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!flush && push) fifo_mem[wr_ptr] <= push_word;
    end
endmodule
